// File: rtl/pc_fetch_unit.sv
// Program counter and next-address stage for the single-cycle MIPS core.
// Chooses the next PC, checks it against the instruction memory, and tracks run state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 100,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jump_reg,
    input  logic [31:0]      rs_value,
    input  logic             halt_req,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic [1:0]       state,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        HALT  = 2'b10,
        FAULT = 2'b11
    } run_state_t;

    localparam logic [1:0]  CAUSE_NONE      = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE     = 2'b10;
    localparam logic [32:0] IMEM_BYTES      = 33'(IMEM_WORDS) * 33'd4;

    run_state_t  state_q;
    logic [31:0] cand;
    logic [1:0]  cand_cause;
    logic [1:0]  boot_cause;

    // Misalignment outranks out-of-range when both apply.
    function automatic logic [1:0] target_fault(input logic [31:0] addr);
        if (addr[1:0] != 2'b00)
            return CAUSE_MISALIGN;
        else if ({1'b0, addr} >= IMEM_BYTES)
            return CAUSE_RANGE;
        else
            return CAUSE_NONE;
    endfunction

    assign pc_plus4    = pc + 32'd4;
    assign fetch_valid = (state_q == RUN);
    assign state       = state_q;

    always_comb begin
        cand = pc_plus4;
        if (jump_reg)
            cand = rs_value;
        else if (jump)
            cand = {pc_plus4[31:28], jump_index, 2'b00};
        else if (branch_taken)
            cand = pc_plus4 + (branch_offset << 2);
    end

    assign cand_cause = target_fault(cand);
    assign boot_cause = target_fault(RESET_PC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc          <= RESET_PC;
            fault_cause <= CAUSE_NONE;
            fetch_count <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    if (boot_cause == CAUSE_NONE) begin
                        state_q <= RUN;
                    end else begin
                        state_q     <= FAULT;
                        fault_cause <= boot_cause;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state_q <= HALT;
                    end else if (!stall) begin
                        if (cand_cause == CAUSE_NONE) begin
                            pc <= cand;
                            if (fetch_count != '1)
                                fetch_count <= fetch_count + CNT_W'(1);
                        end else begin
                            state_q     <= FAULT;
                            fault_cause <= cand_cause;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit, including a 3-bit counter instance.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jump_reg = 1'b0;
    logic [31:0] rs_value = '0;
    logic        halt_req = 1'b0;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid;
    logic [1:0]  state, fault_cause;
    logic [31:0] fetch_count;

    logic        rst2 = 1'b0;
    logic [31:0] pc2, pc_plus4_2;
    logic        fetch_valid2;
    logic [1:0]  state2, fault_cause2;
    logic [2:0]  fetch_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(100), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .rs_value(rs_value), .halt_req(halt_req),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .state(state),
        .fault_cause(fault_cause), .fetch_count(fetch_count)
    );

    pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(100), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst2), .stall(1'b0), .branch_taken(1'b0),
        .branch_offset(32'h0), .jump(1'b0), .jump_index(26'h0),
        .jump_reg(1'b0), .rs_value(32'h0), .halt_req(1'b0),
        .pc(pc2), .pc_plus4(pc_plus4_2), .fetch_valid(fetch_valid2), .state(state2),
        .fault_cause(fault_cause2), .fetch_count(fetch_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; branch_offset = '0; jump = 0;
        jump_index = '0; jump_reg = 0; rs_value = '0; halt_req = 0;
    endtask

    task automatic chk_main(input string name, input logic [31:0] exp_pc, input logic [1:0] exp_state,
                            input logic [1:0] exp_cause, input logic [31:0] exp_cnt);
        checks++;
        if (pc !== exp_pc) begin
            errors++; $display("FAIL %s pc: got %h expected %h", name, pc, exp_pc);
        end
        checks++;
        if (state !== exp_state) begin
            errors++; $display("FAIL %s state: got %b expected %b", name, state, exp_state);
        end
        checks++;
        if (fault_cause !== exp_cause) begin
            errors++; $display("FAIL %s fault_cause: got %b expected %b", name, fault_cause, exp_cause);
        end
        checks++;
        if (fetch_count !== exp_cnt) begin
            errors++; $display("FAIL %s fetch_count: got %0d expected %0d", name, fetch_count, exp_cnt);
        end
        checks++;
        if (fetch_valid !== (exp_state == 2'b01)) begin
            errors++; $display("FAIL %s fetch_valid: got %b expected %b", name, fetch_valid, exp_state == 2'b01);
        end
        checks++;
        if (pc_plus4 !== exp_pc + 32'd4) begin
            errors++; $display("FAIL %s pc_plus4: got %h expected %h", name, pc_plus4, exp_pc + 32'd4);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step(); step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_main("reset_boot", 32'h0, 2'b00, 2'b00, 0);
        step();
        chk_main("boot_to_run", 32'h0, 2'b01, 2'b00, 0);
        step(); chk_main("seq1", 32'h4, 2'b01, 2'b00, 1);
        step(); chk_main("seq2", 32'h8, 2'b01, 2'b00, 2);
        step(); chk_main("seq3", 32'hC, 2'b01, 2'b00, 3);
        step(); chk_main("seq4", 32'h10, 2'b01, 2'b00, 4);
    endtask

    task automatic test_priority();
        branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        step(); chk_main("branch_back", 32'hC, 2'b01, 2'b00, 5);
        jump = 1; jump_index = 26'h20;
        step(); chk_main("jump_over_branch", 32'h80, 2'b01, 2'b00, 6);
        jump_reg = 1; rs_value = 32'h40;
        step(); chk_main("jr_over_jump", 32'h40, 2'b01, 2'b00, 7);
        clear_inputs();
        jump_reg = 1; rs_value = 32'h20;
        step(); chk_main("jr_to_20", 32'h20, 2'b01, 2'b00, 8);
        clear_inputs();
    endtask

    task automatic test_stall();
        stall = 1; jump = 1; jump_index = 26'h30;
        for (int i = 0; i < 3; i++) begin
            step(); chk_main("stall_hold", 32'h20, 2'b01, 2'b00, 8);
        end
        clear_inputs();
        step(); chk_main("stall_release", 32'h24, 2'b01, 2'b00, 9);
    endtask

    task automatic test_fault_misaligned();
        jump_reg = 1; rs_value = 32'h42;
        step(); chk_main("fault_misalign", 32'h24, 2'b11, 2'b01, 9);
        rs_value = 32'h40;
        step(); step();
        chk_main("fault_misalign_sticky", 32'h24, 2'b11, 2'b01, 9);
        clear_inputs();
    endtask

    task automatic test_fault_range();
        do_reset();
        step();
        jump_reg = 1; rs_value = 32'h18C;
        step(); chk_main("jr_to_18c", 32'h18C, 2'b01, 2'b00, 1);
        clear_inputs();
        step(); chk_main("fault_range", 32'h18C, 2'b11, 2'b10, 1);
        jump_reg = 1; rs_value = 32'h0; halt_req = 1;
        step(); step();
        chk_main("fault_range_sticky", 32'h18C, 2'b11, 2'b10, 1);
        clear_inputs();
    endtask

    task automatic test_halt_and_async_reset();
        do_reset();
        step();
        step(); chk_main("pre_halt", 32'h4, 2'b01, 2'b00, 1);
        halt_req = 1; stall = 1;
        step(); chk_main("halt_enter", 32'h4, 2'b10, 2'b00, 1);
        clear_inputs();
        jump_reg = 1; rs_value = 32'h42; jump = 1; jump_index = 26'h10;
        step(); step();
        chk_main("halt_ignores", 32'h4, 2'b10, 2'b00, 1);
        clear_inputs();
        #2 rst = 1;
        #1 chk_main("async_reset", 32'h0, 2'b00, 2'b00, 0);
        #1 rst = 0;
    endtask

    task automatic test_saturation();
        rst2 = 1;
        step(); step();
        rst2 = 0;
        step();
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (fetch_count2 !== 3'd7) begin
            errors++; $display("FAIL sat_count: got %0d expected 7", fetch_count2);
        end
        checks++;
        if (pc2 !== 32'd40) begin
            errors++; $display("FAIL sat_pc: got %h expected %h", pc2, 32'd40);
        end
        checks++;
        if (state2 !== 2'b01) begin
            errors++; $display("FAIL sat_state: got %b expected 01", state2);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stall();
        test_fault_misaligned();
        test_fault_range();
        test_halt_and_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and next-address stage feeding the instruction memory of the MIPS 32 single-cycle processor. Holds the architectural PC and drives it as the fetch address every cycle. Selects the next PC from sequential, branch, jump and jump-register sources. Adds a run-control state machine with stall, halt, fault detection and a retired-fetch counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 100, number of instruction-memory words; the legal fetch range is 0 to IMEM_WORDS*4-1.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset, asynchronous and active-high.
- stall  in  1  hold the PC this cycle.
- branch_taken  in  1  take the branch target.
- branch_offset  in  32  sign-extended word offset (imm16 already extended).
- jump  in  1  take the J/JAL target.
- jump_index  in  26  instr[25:0].
- jump_reg  in  1  take the JR target.
- rs_value  in  32  register value used by JR.
- halt_req  in  1  stop fetching.
- pc  out  32  current PC; connects to the instruction memory address input.
- pc_plus4  out  32  pc + 4, used for the JAL link value.
- fetch_valid  out  1  pc holds a legal instruction being executed this cycle.
- state  out  2  00 BOOT, 01 RUN, 10 HALT, 11 FAULT.
- fault_cause  out  2  00 none, 01 misaligned target, 10 out-of-range target.
- fetch_count  out  CNT_W  number of PC advances made in RUN.

## Operation
- Target computation, all modulo 2^32:
  - seq = pc+4.
  - br = pc+4 + (branch_offset<<2).
  - j = {pc_plus4[31:28], jump_index, 2'b00}.
  - jr = rs_value.
- Selection priority in RUN: halt_req > stall > jump_reg > jump > branch_taken > seq. Branch and jump asserted together: jump wins.
- Candidate check, applied before any PC update:
  - cand[1:0] != 0 → misaligned.
  - cand >= IMEM_WORDS*4 → out of range.
  - Misaligned has priority over out of range.
- FSM:
  - BOOT: pc = RESET_PC, fetch_valid 0. On the next edge, check RESET_PC as a candidate. Legal → RUN. Illegal → FAULT with the matching cause.
  - RUN: fetch_valid 1.
    - halt_req → HALT, pc held.
    - stall → pc held, no count.
    - Otherwise: legal candidate → pc = cand, fetch_count += 1. Illegal candidate → FAULT, pc held at the faulting instruction's address, fault_cause set.
  - HALT: pc held, fetch_valid 0, all control inputs ignored. Exit only by reset.
  - FAULT: pc held, fetch_valid 0, fault_cause held, inputs ignored. Exit only by reset.
- fetch_count saturates at all-ones. It never wraps.
- Only jump_reg can produce a misaligned target. Any path, including seq, can produce an out-of-range target.

## Timing
- Reset, asserted asynchronously:
  - pc=RESET_PC, state=BOOT, fetch_valid=0, fault_cause=00, fetch_count=0.
  - pc_plus4=RESET_PC+4, which is combinational from pc.
- Reset asserted mid-operation immediately forces the reset values, regardless of state. The first RUN cycle is the second rising edge after rst deasserts (BOOT lasts one cycle).
- pc, state, fault_cause and fetch_count are registered. pc_plus4 and fetch_valid are combinational from the registers.
- Control inputs are sampled on the rising edge. The new pc is visible after the same edge. Instruction memory read is combinational, so the instruction at the new pc is available in the same cycle (zero-cycle fetch latency).
- Redirect latency is one edge. There are no delay slots and nothing is flushed.
- stall and halt_req asserted together: HALT.
- Fault detection happens on the edge where the update would occur. The state is FAULT after that edge.

## Test plan
- Reset/boot: rst=1 for 2 cycles, then release with RESET_PC=0 → pc=0 and state=BOOT for 1 cycle, then RUN. pc goes 0,4,8,12 on successive edges; fetch_count=3 after three advances.
- Branch/jump priority, starting at pc=0x10:
  - branch_taken=1, offset=-2 → pc=0x0C.
  - jump=1 with index=0x20 together with branch → pc=0x80.
  - jump_reg=1, rs_value=0x40, with jump also asserted → pc=0x40.
- Stall: at pc=0x20, stall=1 for 3 cycles → pc stays 0x20, fetch_count unchanged. Release → pc=0x24.
- Faults:
  - jump_reg with rs_value=0x42 → state=FAULT, fault_cause=01, pc unchanged, fetch_valid=0.
  - With IMEM_WORDS=100, sequential fetch from pc=0x18C → FAULT, fault_cause=10, pc=0x18C.
  - Neither fault clears without rst.
- Halt and mid-run reset:
  - halt_req with stall → HALT, pc held, inputs ignored.
  - Async rst pulse between clock edges → pc=0 and state=BOOT immediately, before the next edge.
- Counter saturation: CNT_W=3, run 10 sequential advances → fetch_count sticks at 7.
